// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state type and timing helper for the sequential multiplier
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mul_state_t;

  // Edges from one accepted start to the next when St is held high.
  function automatic int mul_latency(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// rtl/seq_mult_ctrl.sv - sequencing FSM and iteration counter for the shift-add multiplier
module seq_mult_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic st,
  output logic load,
  output logic shift,
  output logic fix,
  output logic busy,
  output logic done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mul_state_t       state;
  logic [CNT_W-1:0] cnt;

  assign load  = (state == IDLE) && st;
  assign shift = (state == RUN);
  assign fix   = (state == FIX);

  // The final RUN edge is the one that sees cnt == WIDTH-1, giving exactly WIDTH shift edges.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (st) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - parametrised signed/unsigned shift-add multiplier with held result register
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               St,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   Multiplicando,
  input  logic [WIDTH-1:0]   Multiplicador,
  output logic [2*WIDTH-1:0] Produto,
  output logic               Busy,
  output logic               Done
);

  logic               load;
  logic               shift;
  logic               fix;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               start_neg;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic               neg;
  logic [WIDTH:0]     sum;

  // The most negative value maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  assign mag_a     = magnitude(Multiplicando, Signed);
  assign mag_b     = magnitude(Multiplicador, Signed);
  assign start_neg = Signed & (Multiplicando[WIDTH-1] ^ Multiplicador[WIDTH-1]);
  assign sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

  seq_mult_ctrl #(
    .WIDTH(WIDTH)
  ) u_ctrl (
    .clk   (Clk),
    .resetn(Reset),
    .st    (St),
    .load  (load),
    .shift (shift),
    .fix   (fix),
    .busy  (Busy),
    .done  (Done)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      acc     <= '0;
      mcand   <= '0;
      neg     <= 1'b0;
      Produto <= '0;
    end else begin
      if (load) begin
        acc   <= {{WIDTH{1'b0}}, mag_b};
        mcand <= mag_a;
        neg   <= start_neg;
      end else if (shift) begin
        acc <= {sum, acc[WIDTH-1:1]};
      end
      if (fix) begin
        Produto <= neg ? -acc : acc;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - randomized and directed checks of seq_multiplier at WIDTH 16 and 8
module tb_seq_multiplier;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_v [2];
  logic        sg_v [2];
  logic [15:0] a_v  [2];
  logic [15:0] b_v  [2];
  logic [31:0] p16;
  logic [15:0] p8;
  logic        busy_v [2];
  logic        done_v [2];

  int n_cmp = 0;
  int n_fail = 0;
  int k;
  int dones;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(16)) dut16 (
    .Clk(clk), .Reset(reset), .St(st_v[0]), .Signed(sg_v[0]),
    .Multiplicando(a_v[0]), .Multiplicador(b_v[0]),
    .Produto(p16), .Busy(busy_v[0]), .Done(done_v[0])
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset(reset), .St(st_v[1]), .Signed(sg_v[1]),
    .Multiplicando(a_v[1][7:0]), .Multiplicador(b_v[1][7:0]),
    .Produto(p8), .Busy(busy_v[1]), .Done(done_v[1])
  );

  function automatic int wid(input int u);
    return (u == 0) ? 16 : 8;
  endfunction

  function automatic logic [63:0] prod_v(input int u);
    return (u == 0) ? 64'(p16) : 64'(p8);
  endfunction

  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x, input logic [31:0] y, input bit sgn);
    longint xv, yv;
    logic [63:0] mask;
    mask = (64'd1 << (2 * w)) - 64'd1;
    xv = longint'(x) & ((longint'(1) << w) - 1);
    yv = longint'(y) & ((longint'(1) << w) - 1);
    if (sgn && xv[w-1]) xv = xv - (longint'(1) << w);
    if (sgn && yv[w-1]) yv = yv - (longint'(1) << w);
    return 64'(xv * yv) & mask;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: a start at edge s yields the product at edge s+W+1.
  bit          m_valid = 0;
  bit          m_active [2];
  bit          m_done   [2];
  longint      m_fix    [2];
  longint      m_idle   [2];
  logic [63:0] m_prod   [2];
  logic [63:0] m_pend   [2];
  longint      edge_n = 0;

  always @(posedge clk) begin
    edge_n++;
    for (int u = 0; u < 2; u++) begin
      if (!reset) begin
        m_valid     = 1;
        m_active[u] = 0;
        m_done[u]   = 0;
        m_prod[u]   = '0;
        m_fix[u]    = -1;
        m_idle[u]   = edge_n + 1;
      end else begin
        m_done[u] = 0;
        if (m_active[u] && edge_n == m_fix[u]) begin
          m_prod[u]   = m_pend[u];
          m_done[u]   = 1;
          m_active[u] = 0;
        end
        if (!m_active[u] && edge_n >= m_idle[u] && st_v[u]) begin
          m_pend[u]   = ref_mul(wid(u), 32'(a_v[u]), 32'(b_v[u]), sg_v[u]);
          m_fix[u]    = edge_n + wid(u) + 1;
          m_idle[u]   = edge_n + mul_latency(wid(u));
          m_active[u] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int u = 0; u < 2; u++) begin
        check($sformatf("u%0d_busy", u), 64'(busy_v[u]), 64'(m_active[u]));
        check($sformatf("u%0d_done", u), 64'(done_v[u]), 64'(m_done[u]));
        check($sformatf("u%0d_prod", u), prod_v(u), m_prod[u]);
      end
    end
  end

  task automatic run_op(input int u, input logic [15:0] x, input logic [15:0] y, input bit s,
                        input logic [63:0] lit, input string nm);
    int n;
    int busy_n;
    a_v[u]  = x;
    b_v[u]  = y;
    sg_v[u] = s;
    st_v[u] = 1;
    @(negedge clk);
    st_v[u] = 0;
    n = 1;
    busy_n = 0;
    while (!done_v[u] && n < 40) begin
      if (busy_v[u]) busy_n++;
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, 64'(n), 64'(wid(u) + 2));
    check({nm, "_busycycles"}, 64'(busy_n), 64'(wid(u) + 1));
    check({nm, "_prod"}, prod_v(u), lit);
    check({nm, "_model"}, m_prod[u], lit);
  endtask

  function automatic logic [15:0] pick(input int u);
    int w;
    w = wid(u);
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return 16'((32'd1 << w) - 1);
      2:       return 16'(32'd1 << (w - 1));
      3:       return 16'((32'd1 << (w - 1)) - 1);
      default: return 16'($urandom_range(0, (1 << w) - 1));
    endcase
  endfunction

  initial begin
    reset = 0;
    for (int u = 0; u < 2; u++) begin
      st_v[u] = 0; sg_v[u] = 0; a_v[u] = '0; b_v[u] = '0;
    end
    @(negedge clk);
    reset = 1;
    check("rst_prod", 64'(p16), 64'h0);
    check("rst_busy", 64'(busy_v[0]), 64'h0);
    check("rst_done", 64'(done_v[0]), 64'h0);

    run_op(0, 16'd12, 16'd75, 0, 64'h0000_0384, "t1");

    a_v[0] = 16'hFFFF; b_v[0] = 16'hFFFF; sg_v[0] = 0; st_v[0] = 1;
    @(negedge clk);
    a_v[0] = 16'h0FA1; b_v[0] = 16'h07D1;
    k = 1;
    while (!done_v[0] && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("t2a_latency", 64'(k), 64'd18);
    check("t2a_prod", 64'(p16), 64'hFFFE_0001);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) st_v[0] = 0;
      if (k == 9) check("t2_hold", 64'(p16), 64'hFFFE_0001);
    end while (!done_v[0] && k < 40);
    check("t2b_period", 64'(k), 64'd18);
    check("t2b_prod", 64'(p16), 64'h007A_2971);

    run_op(0, 16'hFFFF, 16'hFFFF, 1, 64'h0000_0001, "t3_m1m1");
    run_op(0, 16'h8000, 16'h8000, 1, 64'h4000_0000, "t3_minmin");
    run_op(0, 16'hFFFD, 16'h0005, 1, 64'hFFFF_FFF1, "t3_m3x5");
    run_op(0, 16'h0000, 16'h8000, 1, 64'h0000_0000, "t3_zero");

    a_v[0] = 16'd7; b_v[0] = 16'd9; sg_v[0] = 0; st_v[0] = 1;
    @(negedge clk);
    st_v[0] = 0;
    k = 1;
    while (!done_v[0] && k < 40) begin
      if (k == 5) begin
        a_v[0] = 16'h1234; b_v[0] = 16'hFFFF; sg_v[0] = 1; st_v[0] = 1;
      end
      if (k == 6) st_v[0] = 0;
      @(negedge clk);
      k++;
    end
    check("t4_latency", 64'(k), 64'd18);
    check("t4_prod", 64'(p16), 64'd63);
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_v[0]) dones++;
    end
    check("t4_no_extra_done", 64'(dones), 64'd0);

    a_v[0] = 16'd5; b_v[0] = 16'd6; sg_v[0] = 0; st_v[0] = 1;
    @(negedge clk);
    st_v[0] = 0;
    k = 1;
    while (k < 8) begin
      @(negedge clk);
      k++;
    end
    reset = 0;
    @(negedge clk);
    reset = 1;
    check("t5_prod", 64'(p16), 64'h0);
    check("t5_busy", 64'(busy_v[0]), 64'h0);
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_v[0]) dones++;
    end
    check("t5_no_done", 64'(dones), 64'd0);
    run_op(0, 16'd3, 16'd4, 0, 64'd12, "t5_restart");

    run_op(1, 16'h00FF, 16'h00FF, 0, 64'hFE01, "t6_u255");
    run_op(1, 16'h0080, 16'h007F, 1, 64'hC080, "t6_s80x7f");

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) != 0);
      for (int u = 0; u < 2; u++) begin
        st_v[u] = ($urandom_range(0, 3) == 0);
        sg_v[u] = 1'($urandom_range(0, 1));
        a_v[u]  = pick(u);
        b_v[u]  = pick(u);
      end
    end
    reset = 1;
    st_v[0] = 0;
    st_v[1] = 0;
    repeat (30) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
